// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit layout and TX FSM states
package mmio_uart_tx_pkg;
    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-bus strobes, address and data for the UART window
interface mmio_uart_tx_if;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master(output we, re, addr, wdata, input rdata);
    modport slave(input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// mmio_uart_tx_fifo: first-word-fall-through byte FIFO with wrapping pointers
module mmio_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_wr;
    logic             w_rd;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_dout  = r_mem[r_rp];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 console transmitter with TX FIFO, sticky
// overflow flag and a per-byte sideband echo of accepted characters.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mmio_uart_tx_if.slave  bus,
    output logic           o_tx,
    output logic           o_tx_busy,
    output logic           o_char_valid,
    output logic [7:0]     o_char_data
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    tx_state_e   r_state;
    tx_state_e   w_next;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_busy;
    logic        r_ovf;
    logic        r_char_valid;
    logic [7:0]  r_char_data;
    logic [31:0] r_rdata;
    logic [31:0] w_status;
    logic [7:0]  w_dout;
    logic        w_hit, w_tx_wr, w_st_rd, w_push, w_pop, w_ovf_set;
    logic        w_full, w_empty, w_bit_end;
    assign w_hit     = bus.addr[31:3] == BASE_ADDR[31:3];
    assign w_tx_wr   = bus.we && w_hit && bus.addr[2:0] == TXDATA_OFS;
    assign w_st_rd   = bus.re && w_hit && bus.addr[2:0] == STATUS_OFS;
    assign w_push    = w_tx_wr && !w_full;
    assign w_ovf_set = w_tx_wr && w_full;
    assign w_bit_end = r_baud == BW'(CLKS_PER_BIT - 1);
    assign o_tx         = r_tx;
    assign o_tx_busy    = r_busy;
    assign o_char_valid = r_char_valid;
    assign o_char_data  = r_char_data;
    assign bus.rdata    = r_rdata;
    mmio_uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (bus.wdata[7:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_comb begin
        w_status         = '0;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_BUSY]  = r_busy;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL]  = w_full;
    end
    // STOP pops directly into START so consecutive frames have no idle gap
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:  if (!w_empty) begin
                w_next = START;
                w_pop  = 1'b1;
            end
            START: if (w_bit_end) w_next = DATA;
            DATA:  if (w_bit_end && r_bit == 3'd7) w_next = STOP;
            STOP:  if (w_bit_end) begin
                w_next = w_empty ? IDLE : START;
                w_pop  = !w_empty;
            end
            default: w_next = IDLE;
        endcase
    end
    // tx follows the state one cycle later so the line is always a clean flop output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_baud  <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
            r_bit   <= (r_state == DATA && w_bit_end) ? r_bit + 1'b1 : r_bit;
            if (w_pop) r_shift <= w_dout;
            else if (r_state == DATA && w_bit_end) r_shift <= r_shift >> 1;
            r_tx    <= r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
        end
    end
    // a same-cycle overflow wins over the clear-on-read of STATUS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata      <= '0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_data  <= '0;
        end else begin
            r_rdata      <= w_st_rd ? w_status : '0;
            r_ovf        <= w_ovf_set || (r_ovf && !w_st_rd);
            r_busy       <= r_state != IDLE || !w_empty || w_push;
            r_char_valid <= w_push;
            if (w_push) r_char_data <= bus.wdata[7:0];
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random bus traffic checked cycle by cycle
// against a frame-schedule model of the transmitter.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int C = 4;
    localparam int FRAME = 10 * C;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx, tx_busy, char_valid;
    logic [7:0] char_data;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         q_t[$];
    int         q_start[$];
    logic [7:0] q_byte[$];
    bit         m_ovf = 1'b0;
    bit         exp_cv = 1'b0;
    logic [7:0] exp_cd = '0;
    logic [31:0] exp_rd = '0;
    mmio_uart_tx_if bus();
    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_tx         (tx),
        .o_tx_busy    (tx_busy),
        .o_char_valid (char_valid),
        .o_char_data  (char_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // bytes held in the FIFO just before edge e: pushed earlier, popped at e or later
    function automatic int count_at(int e);
        int n = 0;
        foreach (q_t[i]) if (q_t[i] < e && q_start[i] - 1 >= e) n++;
        return n;
    endfunction
    function automatic bit busy_at(int n);
        foreach (q_t[i]) if (q_t[i] <= n && n < q_start[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction
    function automatic bit tx_at(int n);
        foreach (q_t[i]) if (n >= q_start[i] && n < q_start[i] + FRAME) begin
            int b = (n - q_start[i]) / C;
            logic [7:0] v = q_byte[i];
            return b == 0 ? 1'b0 : b == 9 ? 1'b1 : v[b-1];
        end
        return 1'b1;
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        bus.we = 1'b0;
        bus.re = 1'b0;
        chk("tx", tx, tx_at(cyc));
        chk("tx_busy", tx_busy, busy_at(cyc));
        chk("char_valid", char_valid, exp_cv);
        if (exp_cv) chk("char_data", char_data, exp_cd);
        chk("rdata", bus.rdata, exp_rd);
        exp_cv = 1'b0;
        exp_rd = '0;
    endtask
    task automatic idle(int n);
        repeat (n) tick();
    endtask
    task automatic op(bit we, bit re, logic [31:0] addr, logic [31:0] wd);
        int e = cyc + 1;
        int st;
        bit hit = addr[31:3] == BASE[31:3];
        bit set = 1'b0;
        bus.we = we;
        bus.re = re;
        bus.addr = addr;
        bus.wdata = wd;
        if (re && hit && addr[2:0] == 3'd4)
            exp_rd = {28'b0, m_ovf, busy_at(e - 1), count_at(e) == 0, count_at(e) == 8};
        if (we && hit && addr[2:0] == 3'd0) begin
            if (count_at(e) < 8) begin
                st = e + 2;
                if (q_start.size() > 0 && q_start[$] + FRAME > st) st = q_start[$] + FRAME;
                q_t.push_back(e);
                q_start.push_back(st);
                q_byte.push_back(wd[7:0]);
                exp_cv = 1'b1;
                exp_cd = wd[7:0];
            end else set = 1'b1;
        end
        if (set) m_ovf = 1'b1;
        else if (re && hit && addr[2:0] == 3'd4) m_ovf = 1'b0;
        tick();
    endtask
    initial begin
        logic [31:0] addrs [4];
        addrs[0] = BASE;
        addrs[1] = BASE + 4;
        addrs[2] = BASE + 8;
        addrs[3] = 32'h2000_0000;
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        idle(3);
        rst_n = 1'b1;
        op(1, 0, BASE, 32'h48);
        idle(45);
        op(1, 0, BASE, 32'h48 | 32'h100);
        op(1, 0, BASE, 32'h69);
        idle(90);
        for (int i = 0; i < 10; i++) op(1, 0, BASE, $urandom);
        op(0, 1, BASE + 4, 0);
        op(0, 1, BASE + 4, 0);
        idle(400);
        op(1, 0, BASE, 32'h5A);
        idle(12);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_busy", tx_busy, 0);
        q_t.delete();
        q_start.delete();
        q_byte.delete();
        m_ovf = 1'b0;
        exp_cv = 1'b0;
        idle(3);
        rst_n = 1'b1;
        op(0, 1, BASE + 4, 0);
        idle(50);
        op(0, 1, BASE + 8, 0);
        op(0, 1, BASE, 0);
        op(1, 0, BASE + 12, 32'h77);
        op(1, 0, 32'h2000_0000, 32'h33);
        op(0, 1, BASE + 4, 0);
        op(1, 0, BASE, 32'h00);
        op(1, 0, BASE, 32'hFF);
        idle(90);
        for (int i = 0; i < 60; i++) begin
            op($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               addrs[$urandom_range(0, 3)], $urandom);
            idle($urandom_range(0, 20));
        end
        idle(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
